// File: rtl/tos_cache_pkg.sv
// rtl/tos_cache_pkg.sv - shared stack opcode definitions for the top-of-stack cache
// Contents: TOS_OP_W (opcode width) and tos_op_t (the 8 stack opcodes).
// Also imported by the instruction decoder and by the return-stack instance.
package tos_cache_pkg;

  localparam int TOS_OP_W = 3;

  typedef enum logic [TOS_OP_W-1:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_DROP    = 3'd2,
    OP_DUP     = 3'd3,
    OP_SWAP    = 3'd4,
    OP_OVER    = 3'd5,
    OP_NIP     = 3'd6,
    OP_REPLACE = 3'd7
  } tos_op_t;

endpackage

// File: rtl/tos_guard.sv
// rtl/tos_guard.sv - combinational depth guard for the top-of-stack cache
// Ports:
//   op      in   opcode for this cycle
//   depth   in   current element count, including T
//   legal   out  op may execute
//   set_ovf out  op would exceed the 2**saddr_width element capacity
//   set_unf out  op needs more elements than are present
module tos_guard
  import tos_cache_pkg::*;
#(
  parameter int saddr_width = 8
) (
  input  tos_op_t              op,
  input  logic [saddr_width:0] depth,
  output logic                 legal,
  output logic                 set_ovf,
  output logic                 set_unf
);

  localparam int DW = saddr_width + 1;
  localparam logic [saddr_width:0] CAP = DW'(1) << saddr_width;
  localparam logic [saddr_width:0] TWO = DW'(2);

  logic need_one;
  logic need_two;
  logic need_room;

  always_comb begin
    need_one  = 1'b0;
    need_two  = 1'b0;
    need_room = 1'b0;
    case (op)
      OP_PUSH: need_room = 1'b1;
      OP_DROP: need_one  = 1'b1;
      OP_DUP: begin
        need_one  = 1'b1;
        need_room = 1'b1;
      end
      OP_SWAP: need_two = 1'b1;
      OP_OVER: begin
        need_two  = 1'b1;
        need_room = 1'b1;
      end
      OP_NIP: need_two = 1'b1;
      default: ;
    endcase
  end

  assign set_unf = (need_one && (depth == '0)) || (need_two && (depth < TWO));
  assign set_ovf = need_room && (depth >= CAP);
  assign legal   = !set_unf && !set_ovf;

endmodule

// File: rtl/tos_cache.sv
// rtl/tos_cache.sv - top-of-stack cache and stack-op sequencer
// Optional feature macro: STACK_GUARD_EN (depth counter, guards, sticky flags, clr_err).
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wait_state            stall: T, depth and flags hold while high
//   op, din               stack opcode and operand for PUSH/REPLACE
//   T, N                  top of stack (registered), second element (= stk_Q)
//   stk_D, stk_dec,
//   stk_change, stk_update  write data / direction / SP enable / write enable to memory stack
//   stk_Q                 memory stack read data at current SP
//   depth                 element count including T
//   overflow, underflow   sticky guard flags; clr_err clears both
module tos_cache
  import tos_cache_pkg::*;
#(
  parameter int width       = 16,
  parameter int saddr_width = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wait_state,
  input  logic [TOS_OP_W-1:0]   op,
  input  logic [width-1:0]      din,
  output logic [width-1:0]      T,
  output logic [width-1:0]      N,
  output logic [width-1:0]      stk_D,
  output logic                  stk_dec,
  output logic                  stk_change,
  output logic                  stk_update,
  input  logic [width-1:0]      stk_Q,
  output logic [saddr_width:0]  depth,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  tos_op_t op_e;
  logic    legal;

  assign op_e  = tos_op_t'(op);
  assign N     = stk_Q;
  assign stk_D = T;

`ifdef STACK_GUARD_EN
  localparam logic [saddr_width:0] DEPTH_ONE = (saddr_width + 1)'(1);

  logic                 set_ovf;
  logic                 set_unf;
  logic [saddr_width:0] depth_q;
  logic                 ovf_q;
  logic                 unf_q;

  tos_guard #(
    .saddr_width(saddr_width)
  ) u_guard (
    .op      (op_e),
    .depth   (depth_q),
    .legal   (legal),
    .set_ovf (set_ovf),
    .set_unf (set_unf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_q <= '0;
    end else if (!wait_state && legal) begin
      case (op_e)
        OP_PUSH, OP_DUP, OP_OVER: depth_q <= depth_q + DEPTH_ONE;
        OP_DROP, OP_NIP:          depth_q <= depth_q - DEPTH_ONE;
        default: ;
      endcase
    end
  end

  // A new fault in the same cycle as clr_err leaves its flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!wait_state) begin
      ovf_q <= set_ovf || (ovf_q && !clr_err);
      unf_q <= set_unf || (unf_q && !clr_err);
    end
  end

  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_clr_err;

  assign unused_clr_err = clr_err;
  assign legal          = 1'b1;
  assign depth          = '0;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

  // Suppressed ops drive no stack controls so the memory stack's SP keeps
  // tracking depth.
  always_comb begin
    stk_change = 1'b0;
    stk_dec    = 1'b0;
    stk_update = 1'b0;
    if (legal) begin
      case (op_e)
        OP_PUSH, OP_DUP, OP_OVER: begin
          stk_change = 1'b1;
          stk_update = 1'b1;
        end
        OP_DROP, OP_NIP: begin
          stk_change = 1'b1;
          stk_dec    = 1'b1;
        end
        OP_SWAP: stk_update = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      T <= '0;
    end else if (!wait_state && legal) begin
      case (op_e)
        OP_PUSH, OP_REPLACE:       T <= din;
        OP_DROP, OP_SWAP, OP_OVER: T <= stk_Q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tos_cache.sv
// tb/tb_tos_cache.sv - self-checking bench for tos_cache with a behavioural memory stack
module tb_tos_cache;
  import tos_cache_pkg::*;

  localparam int W   = 16;
  localparam int AW  = 2;
  localparam int CAP = 4;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wait_state = 1'b0;
  tos_op_t       op = OP_NOP;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  T, N, stk_D, stk_Q;
  logic          stk_dec, stk_change, stk_update;
  logic [AW:0]   depth;
  logic          overflow, underflow;
  logic          clr_err = 1'b0;

  always #5 clk = ~clk;

  tos_cache #(.width(W), .saddr_width(AW)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wait_state (wait_state),
    .op         (op),
    .din        (din),
    .T          (T),
    .N          (N),
    .stk_D      (stk_D),
    .stk_dec    (stk_dec),
    .stk_change (stk_change),
    .stk_update (stk_update),
    .stk_Q      (stk_Q),
    .depth      (depth),
    .overflow   (overflow),
    .underflow  (underflow),
    .clr_err    (clr_err)
  );

  // Memory stack environment: push pre-increments SP and writes there,
  // pop post-decrements, update alone writes at the current SP.
  logic [W-1:0]  mem [CAP];
  logic [AW-1:0] sp;
  assign stk_Q = mem[sp];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp <= '0;
      for (int k = 0; k < CAP; k++) mem[k] <= '0;
    end else if (!wait_state) begin
      if (stk_change) begin
        if (stk_dec) sp <= sp - 1'b1;
        else begin
          sp <= sp + 1'b1;
          if (stk_update) mem[sp + 1'b1] <= stk_D;
        end
      end else if (stk_update) begin
        mem[sp] <= stk_D;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Stack-control triple {change, dec, update} for an op that is allowed to run.
  function automatic logic [2:0] exp_ctl(input tos_op_t o, input bit ok);
    logic [2:0] r;
    case (o)
      OP_PUSH, OP_DUP, OP_OVER: r = 3'b101;
      OP_DROP, OP_NIP:          r = 3'b110;
      OP_SWAP:                  r = 3'b001;
      default:                  r = 3'b000;
    endcase
    return ok ? r : 3'b000;
  endfunction

  // Reference model: T plus everything beneath it as a queue (top at q[$]).
  logic [W-1:0] q[$];
  logic [W-1:0] t_m;
  bit           ovf_m, unf_m;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; op = OP_NOP; din = '0; wait_state = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q.delete(); t_m = '0; ovf_m = 0; unf_m = 0;
  endtask

  task automatic drive(input tos_op_t o, input logic [W-1:0] d, input logic w, input logic c);
    @(negedge clk);
    op = o; din = d; wait_state = w; clr_err = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    tos_op_t      o;
    logic [W-1:0] d;
    logic         w;
    logic [W-1:0] t;
    logic [W-1:0] n;
    bit           chk_n;
    int           dep;
  } vec_t;

  vec_t vecs[$];

  initial begin
    tos_op_t      o;
    logic [W-1:0] d, tmp;
    logic         w, c;
    int           sz, mn;
    bit           room, ok, so, su;

    vecs = '{
      '{OP_PUSH,    16'h1111, 1'b0, 16'h1111, 16'h0000, 1'b1, 1},
      '{OP_PUSH,    16'h2222, 1'b0, 16'h2222, 16'h1111, 1'b1, 2},
      '{OP_PUSH,    16'h3333, 1'b0, 16'h3333, 16'h2222, 1'b1, 3},
      '{OP_SWAP,    16'h0000, 1'b0, 16'h2222, 16'h3333, 1'b1, 3},
      '{OP_OVER,    16'h0000, 1'b0, 16'h3333, 16'h2222, 1'b1, 4},
      '{OP_NIP,     16'h0000, 1'b0, 16'h3333, 16'h3333, 1'b1, 3},
      '{OP_DROP,    16'h0000, 1'b0, 16'h3333, 16'h1111, 1'b1, 2},
      '{OP_REPLACE, 16'h5555, 1'b0, 16'h5555, 16'h1111, 1'b1, 2},
      '{OP_NOP,     16'h9999, 1'b0, 16'h5555, 16'h1111, 1'b1, 2},
      '{OP_DUP,     16'h0000, 1'b0, 16'h5555, 16'h5555, 1'b1, 3},
      '{OP_PUSH,    16'hAAAA, 1'b1, 16'h5555, 16'h5555, 1'b1, 3},
      '{OP_PUSH,    16'hAAAA, 1'b1, 16'h5555, 16'h5555, 1'b1, 3},
      '{OP_PUSH,    16'hAAAA, 1'b1, 16'h5555, 16'h5555, 1'b1, 3},
      '{OP_PUSH,    16'hAAAA, 1'b0, 16'hAAAA, 16'h5555, 1'b1, 4},
      '{OP_DROP,    16'h0000, 1'b0, 16'h5555, 16'h5555, 1'b1, 3},
      '{OP_DROP,    16'h0000, 1'b0, 16'h5555, 16'h1111, 1'b1, 2},
      '{OP_DROP,    16'h0000, 1'b0, 16'h1111, 16'h0000, 1'b1, 1},
      '{OP_DROP,    16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 0}
    };

    // Reset state
    do_reset();
    #1;
    chk("reset_T", T, 0);
    chk("reset_depth", depth, 0);
    chk("reset_flags", {overflow, underflow}, 0);

    // Directed table
    foreach (vecs[i]) begin
      drive(vecs[i].o, vecs[i].d, vecs[i].w, 1'b0);
      chk($sformatf("tbl%0d_ctl", i), {stk_change, stk_dec, stk_update}, exp_ctl(vecs[i].o, 1));
      tick();
      chk($sformatf("tbl%0d_T", i), T, vecs[i].t);
      if (vecs[i].chk_n) chk($sformatf("tbl%0d_N", i), N, vecs[i].n);
      chk($sformatf("tbl%0d_depth", i), depth, GUARD ? vecs[i].dep : 0);
      chk($sformatf("tbl%0d_flags", i), {overflow, underflow}, 0);
    end

    // Underflow at depth 0, sticky, clr_err, set-wins-over-clear
    do_reset();
    drive(OP_DROP, 16'h0, 1'b0, 1'b0);
    chk("unf_ctl", {stk_change, stk_dec, stk_update}, GUARD ? 3'b000 : 3'b110);
    tick();
    chk("unf_T", T, 0);
    chk("unf_set", underflow, GUARD);
    drive(OP_NOP, 16'h0, 1'b0, 1'b0);
    tick();
    chk("unf_sticky", underflow, GUARD);
    drive(OP_NOP, 16'h0, 1'b1, 1'b1);
    tick();
    chk("unf_clr_stalled", underflow, GUARD);
    drive(OP_NOP, 16'h0, 1'b0, 1'b1);
    tick();
    chk("unf_clr", underflow, 0);
    do_reset();
    drive(OP_DROP, 16'h0, 1'b0, 1'b1);
    tick();
    chk("unf_set_wins", underflow, GUARD);

    // Overflow at capacity
    do_reset();
    for (int k = 1; k <= CAP; k++) begin
      drive(OP_PUSH, W'(k), 1'b0, 1'b0);
      tick();
    end
    chk("ovf_pre_depth", depth, GUARD ? CAP : 0);
    drive(OP_PUSH, 16'hBEEF, 1'b0, 1'b0);
    chk("ovf_ctl", {stk_change, stk_dec, stk_update}, GUARD ? 3'b000 : 3'b101);
    tick();
    chk("ovf_T", T, GUARD ? 16'h0004 : 16'hBEEF);
    chk("ovf_depth", depth, GUARD ? CAP : 0);
    chk("ovf_flag", {overflow, underflow}, GUARD ? 2'b10 : 2'b00);

    // Asynchronous reset mid-cycle at depth 3 with a flag set
    do_reset();
    drive(OP_DROP, 16'h0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(OP_PUSH, 16'h7000 + W'(k), 1'b0, 1'b0);
      tick();
    end
    chk("arst_pre_T", T, 16'h7002);
    chk("arst_pre_depth", depth, GUARD ? 3 : 0);
    drive(OP_PUSH, 16'hDEAD, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("arst_T", T, 0);
    chk("arst_depth", depth, 0);
    chk("arst_flags", {overflow, underflow}, 0);

    // Randomized ops against the queue model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      o = tos_op_t'($urandom_range(0, 7));
      d = W'($urandom);
      w = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 7) == 0);
      sz = q.size();
      mn = (o == OP_DROP || o == OP_DUP) ? 1 :
           (o == OP_SWAP || o == OP_OVER || o == OP_NIP) ? 2 : 0;
      room = (o == OP_PUSH || o == OP_DUP || o == OP_OVER);
      su = (sz < mn);
      so = room && (sz >= CAP);
      ok = !su && !so;
      if (!GUARD && !ok) begin
        o = OP_REPLACE; ok = 1; su = 0; so = 0;
      end
      drive(o, d, w, c);
      chk("rnd_ctl", {stk_change, stk_dec, stk_update}, exp_ctl(o, ok));
      chk("rnd_D", stk_D, t_m);
      if (!w) begin
        if (ok) begin
          case (o)
            OP_PUSH:    begin q.push_back(t_m); t_m = d; end
            OP_DROP:    t_m = q.pop_back();
            OP_DUP:     q.push_back(t_m);
            OP_SWAP:    begin tmp = q[$]; q[$] = t_m; t_m = tmp; end
            OP_OVER:    begin tmp = q[$]; q.push_back(t_m); t_m = tmp; end
            OP_NIP:     void'(q.pop_back());
            OP_REPLACE: t_m = d;
            default: ;
          endcase
        end
        ovf_m = so || (ovf_m && !c);
        unf_m = su || (unf_m && !c);
      end
      tick();
      chk("rnd_T", T, t_m);
      if (q.size() > 0) chk("rnd_N", N, q[$]);
      chk("rnd_depth", depth, GUARD ? q.size() : 0);
      chk("rnd_flags", {overflow, underflow}, {ovf_m, unf_m});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/tos_cache.md
# tos_cache

Top-of-stack cache and stack-op sequencer for the Forth CPU data and return stacks. It holds the top element T in a register and translates one stack opcode per cycle into the push/pop/write controls of the downstream memory stack. It consumes that stack's combinational read port as N, the second element, and tracks depth with sticky overflow/underflow guards. It sits between the instruction decoder/ALU and the memory stack.

## Interface
- width, 16, data word width
- saddr_width, 8, address width of the downstream stack; depth counter is saddr_width+1 bits
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- wait_state  in  1  stall: no register updates while high
- op  in  3  stack opcode for this cycle
- din  in  width  operand for PUSH/REPLACE
- T  out  width  registered top of stack
- N  out  width  second element; equals stk_Q
- stk_D  out  width  write data to memory stack
- stk_dec  out  1  direction to memory stack (1 = decrement)
- stk_change  out  1  SP change enable to memory stack
- stk_update  out  1  write enable to memory stack
- stk_Q  in  width  memory stack read data at current SP
- depth  out  saddr_width+1  element count including T
- overflow  out  1  sticky overflow flag
- underflow  out  1  sticky underflow flag
- clr_err  in  1  clears both sticky flags

## Operation
- Opcodes: 0 NOP; 1 PUSH; 2 DROP; 3 DUP; 4 SWAP; 5 OVER; 6 NIP; 7 REPLACE.
- Control outputs are combinational from op and the guard result. stk_D = T always.
- PUSH: change=1, dec=0, update=1; T<=din; depth+1.
- DROP: change=1, dec=1, update=0; T<=stk_Q; depth-1.
- DUP: change=1, dec=0, update=1; T unchanged; depth+1.
- SWAP: change=0, update=1 (old T written at current SP); T<=stk_Q; depth unchanged.
- OVER: change=1, dec=0, update=1; T<=stk_Q; depth+1.
- NIP: change=1, dec=1, update=0; T unchanged; depth-1.
- REPLACE and NOP: all stack controls 0. REPLACE sets T<=din.
- Capacity: 2**saddr_width elements (2**saddr_width-1 in memory plus T).
- Guard minimums: DROP and DUP need depth>=1; SWAP, OVER and NIP need depth>=2.
- Guard maximum: PUSH, DUP and OVER need depth<2**saddr_width.
- A failing op is suppressed: all stack controls 0, T and depth unchanged, and the matching sticky flag is set.
- clr_err clears both flags. If clr_err coincides with a new fault, the set wins.
- Reset: T=0, depth=0, overflow=0, underflow=0. The memory stack's reset must be asserted over the same cycles so that depth 0 corresponds to SP 0.

## Timing
- Single-cycle ops. T, depth and the flags update on the clk edge where wait_state=0.
- Memory-stack write and SP move occur on that same edge.
- N is valid combinationally in the cycle after any op.
- wait_state=1 freezes T, depth, flags and clr_err effect. Controls may still toggle, because the memory stack ignores them while stalled.
- Back-to-back ops need no bubbles: stk_Q reflects the new SP in the following cycle.
- Reset mid-stall or mid-op takes effect immediately and asynchronously; the in-flight op is discarded.

## Configuration
- STACK_GUARD_EN defined: depth counter, guards, overflow/underflow and clr_err are active as described.
- STACK_GUARD_EN undefined: every op executes unconditionally, and SP wraps modulo 2**saddr_width. depth, overflow and underflow are tied to 0, and clr_err is ignored.

## Structure
- Shared package: opcode enum (tos_op_t with the 8 values above) and constant TOS_OP_W=3.
- The package is reused by the decoder and the return-stack instance.
- One sub-module, tos_guard. It is combinational: op + depth give legal, set_ovf and set_unf, and it is instantiated only under STACK_GUARD_EN.
- Opcode to control mapping and T/depth registers stay in tos_cache.

## Test plan
- Reset, then PUSH 0x1111, PUSH 0x2222, PUSH 0x3333 -> T=0x3333, N=0x2222, depth=3.
- From that state, SWAP -> T=0x2222, N=0x3333, depth=3. OVER -> T=0x3333, N=0x2222, depth=4.
- DROP at depth=0 -> no stack controls, T=0, underflow=1 and it stays set. clr_err pulse -> underflow=0.
- saddr_width=2: PUSH 4 values then a 5th PUSH of 0xBEEF -> 5th PUSH suppressed, overflow=1, T and depth=4 unchanged.
- PUSH 0xAAAA with wait_state=1 for 3 cycles -> T, depth and the memory stack unchanged. The PUSH completes on the first edge after wait_state falls.
- Assert reset_n low mid-sequence at depth=3 -> T, depth and flags become 0 immediately, before the next clk edge.
